// File: rtl/subword_mem_unit_if.sv
// Bus bundle between the datapath memory stage, the subword_mem_unit and the
// word-only data memory port. The slave view belongs to the unit itself; the
// master view is the opposite side (datapath requests plus memory responses).
interface subword_mem_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_ren;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              ready;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dhit;

    modport slave (
        input  req_ren, req_wen, req_addr, req_wdata, req_size, req_signed,
        input  dload, dhit,
        output ready, err, rdata, dREN, dWEN, daddr, dstore
    );

    modport master (
        output req_ren, req_wen, req_addr, req_wdata, req_size, req_signed,
        output dload, dhit,
        input  ready, err, rdata, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/subword_mem_unit.sv
// Sub-word load/store adapter for a big-endian, word-only data memory.
// Loads pull a byte or halfword lane out of the addressed word and extend it
// to 32 bits; sub-word stores do a read-modify-write of the containing word.
// Illegal or misaligned requests are answered with err and never touch memory.
module subword_mem_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    subword_mem_unit_if.slave bus
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t state;
    state_t next_state;

    // Request captured in IDLE; the datapath is free to change its inputs
    // afterwards, so everything downstream works from these copies.
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              store_q;
    logic              err_q;

    // Registered results presented to the datapath and the memory.
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] dstore_q;

    logic req_any;
    logic req_bad;
    logic req_word_store;

    // Pull the addressed lane out of a big-endian word and extend it.
    // Byte offset 0 is the most significant byte of the word.
    function automatic logic [31:0] extract_lane(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        r = word;
        case (lo)
            2'b00:   b = word[31:24];
            2'b01:   b = word[23:16];
            2'b10:   b = word[15:8];
            default: b = word[7:0];
        endcase
        h = lo[1] ? word[15:0] : word[31:16];
        case (size)
            SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
            SIZE_HALF: r = {{16{sgn & h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of a big-endian word with new store data,
    // leaving the remaining lanes exactly as read from memory.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [15:0] wd,
        input logic [1:0]  lo,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = word;
        case (size)
            SIZE_BYTE: begin
                case (lo)
                    2'b00:   r[31:24] = wd[7:0];
                    2'b01:   r[23:16] = wd[7:0];
                    2'b10:   r[15:8]  = wd[7:0];
                    default: r[7:0]   = wd[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lo[1]) begin
                    r[15:0] = wd;
                end else begin
                    r[31:16] = wd;
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Classify the incoming request: present at all, illegal, or a full-word store.
    always_comb begin
        req_any        = bus.req_ren | bus.req_wen;
        req_bad        = 1'b0;
        req_word_store = 1'b0;
        if (bus.req_ren && bus.req_wen) begin
            req_bad = 1'b1;
        end
        if (bus.req_size == 2'b11) begin
            req_bad = 1'b1;
        end
        if ((bus.req_size == SIZE_HALF) && bus.req_addr[0]) begin
            req_bad = 1'b1;
        end
        if ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
        if (bus.req_wen && !bus.req_ren && (bus.req_size == SIZE_WORD)) begin
            req_word_store = 1'b1;
        end
    end

    // State register; reset drops any access in flight straight back to IDLE.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the handshake/enable outputs, all from the current state.
    always_comb begin
        next_state = state;
        bus.ready  = 1'b0;
        bus.err    = 1'b0;
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (req_bad) begin
                        next_state = DONE;
                    end else if (req_word_store) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                bus.dREN = 1'b1;
                if (bus.dhit) begin
                    next_state = store_q ? WR : DONE;
                end
            end
            WR: begin
                bus.dWEN = 1'b1;
                if (bus.dhit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.ready  = 1'b1;
                bus.err    = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the request in IDLE and register load results / merged store words.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            dstore_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata[15:0];
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        store_q  <= bus.req_wen;
                        err_q    <= req_bad;
                        if (req_word_store && !req_bad) begin
                            dstore_q <= bus.req_wdata;
                        end
                    end
                end
                RD: begin
                    if (bus.dhit) begin
                        if (store_q) begin
                            dstore_q <= merge_lane(bus.dload, wdata_q, addr_q[1:0], size_q);
                        end else begin
                            rdata_q <= extract_lane(bus.dload, addr_q[1:0], size_q, signed_q);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.daddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.dstore = dstore_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_subword_mem_unit.sv
// Directed bench for subword_mem_unit: a small word memory model with
// programmable hit delays answers the unit, and each transaction's result,
// latency and memory traffic are compared against hand-computed values.
module tb_subword_mem_unit;

    logic CLK;
    logic nRST;

    subword_mem_unit_if bus ();

    subword_mem_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] mem [0:511];
    int          rd_delay;
    int          wr_delay;
    int          wait_cnt;
    logic        pre_en;
    logic [31:0] pre_addr;
    logic [31:0] pre_data;

    int          check_count;
    int          fail_count;

    int          rd_beats;
    int          wr_beats;
    int          en_cycles;
    int          overlap_cycles;
    int          ready_count;
    logic [31:0] last_rd_addr;
    logic [31:0] last_wr_data;

    int          res_cycles;
    logic        res_timeout;
    logic        res_err;
    logic [31:0] res_rdata;
    int          res_rd;
    int          res_wr;
    int          res_en;
    int          ready0;

    // Memory answers after a programmable number of wait cycles.
    assign bus.dhit  = (bus.dREN && (wait_cnt == rd_delay)) || (bus.dWEN && (wait_cnt == wr_delay));
    assign bus.dload = mem[bus.daddr[10:2]];

    // Memory model: completes writes on dhit, tracks wait cycles, accepts preloads.
    always @(posedge CLK) begin
        if (pre_en) begin
            mem[pre_addr[10:2]] <= pre_data;
        end
        if (bus.dWEN && bus.dhit) begin
            mem[bus.daddr[10:2]] <= bus.dstore;
        end
        if ((bus.dREN || bus.dWEN) && !bus.dhit) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // Bus monitor: counts completed memory beats, enable cycles, overlaps and ready pulses.
    always @(negedge CLK) begin
        if (bus.dREN && bus.dWEN) overlap_cycles <= overlap_cycles + 1;
        if (bus.dREN || bus.dWEN) en_cycles <= en_cycles + 1;
        if (bus.ready) ready_count <= ready_count + 1;
        if (bus.dREN && bus.dhit) begin
            rd_beats     <= rd_beats + 1;
            last_rd_addr <= bus.daddr;
        end
        if (bus.dWEN && bus.dhit) begin
            wr_beats     <= wr_beats + 1;
            last_wr_data <= bus.dstore;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic memPreload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        pre_addr = addr;
        pre_data = data;
        pre_en   = 1'b1;
        @(posedge CLK);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic driveIdle();
        bus.req_ren    = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
    endtask

    // Present one request, hold it until ready, record result and traffic.
    // Cycle 1 is the sampling cycle; res_cycles is the cycle in which ready is seen.
    task automatic applyStimulus(input logic ren, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size,
                                 input logic sgn, input int rdly, input int wdly);
        int rd0;
        int wr0;
        int en0;
        @(negedge CLK);
        rd_delay       = rdly;
        wr_delay       = wdly;
        rd0            = rd_beats;
        wr0            = wr_beats;
        en0            = en_cycles;
        bus.req_ren    = ren;
        bus.req_wen    = wen;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_size   = size;
        bus.req_signed = sgn;
        res_cycles     = 1;
        res_timeout    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            res_cycles++;
            if (bus.ready) begin
                res_timeout = 1'b0;
                break;
            end
        end
        res_err   = bus.err;
        res_rdata = bus.rdata;
        driveIdle();
        @(posedge CLK);
        #1;
        res_rd = rd_beats - rd0;
        res_wr = wr_beats - wr0;
        res_en = en_cycles - en0;
        if (res_timeout) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_count    = 0;
        fail_count     = 0;
        rd_beats       = 0;
        wr_beats       = 0;
        en_cycles      = 0;
        overlap_cycles = 0;
        ready_count    = 0;
        last_rd_addr   = 32'h0;
        last_wr_data   = 32'h0;
        wait_cnt       = 0;
        rd_delay       = 0;
        wr_delay       = 0;
        pre_en         = 1'b0;
        pre_addr       = 32'h0;
        pre_data       = 32'h0;
        nRST           = 1'b0;
        driveIdle();

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_ready",  {31'd0, bus.ready}, 32'd0);
        checkOutput("rst_err",    {31'd0, bus.err},   32'd0);
        checkOutput("rst_dREN",   {31'd0, bus.dREN},  32'd0);
        checkOutput("rst_dWEN",   {31'd0, bus.dWEN},  32'd0);
        checkOutput("rst_rdata",  bus.rdata,          32'h0);
        checkOutput("rst_daddr",  bus.daddr,          32'h0);
        checkOutput("rst_dstore", bus.dstore,         32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        $display("[TB] signed byte load");
        memPreload(32'h100, 32'h1280_FF34);
        applyStimulus(1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 1'b1, 0, 0);
        checkOutput("sb_rdata",  res_rdata,          32'hFFFF_FF80);
        checkOutput("sb_cycles", res_cycles,         32'd3);
        checkOutput("sb_err",    {31'd0, res_err},   32'd0);
        checkOutput("sb_daddr",  last_rd_addr,       32'h100);
        checkOutput("sb_reads",  res_rd,             32'd1);
        checkOutput("sb_writes", res_wr,             32'd0);

        $display("[TB] lane extraction variants");
        memPreload(32'h100, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 0, 0);
        checkOutput("uh_rdata", res_rdata, 32'h0000_BEEF);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b01, 1'b1, 0, 0);
        checkOutput("sh_rdata", res_rdata, 32'hFFFF_DEAD);
        applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 0, 0);
        checkOutput("ub_rdata", res_rdata, 32'h0000_00EF);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 1'b1, 1, 0);
        checkOutput("sb0_rdata",  res_rdata,  32'hFFFF_FFDE);
        checkOutput("sb0_cycles", res_cycles, 32'd4);

        $display("[TB] byte store with delayed hits");
        memPreload(32'h200, 32'h1122_3344);
        applyStimulus(1'b0, 1'b1, 32'h203, 32'h0000_00AB, 2'b00, 1'b0, 2, 2);
        checkOutput("bs_cycles",  res_cycles,     32'd8);
        checkOutput("bs_reads",   res_rd,         32'd1);
        checkOutput("bs_writes",  res_wr,         32'd1);
        checkOutput("bs_dstore",  last_wr_data,   32'h1122_33AB);
        checkOutput("bs_mem",     mem[9'h080],    32'h1122_33AB);
        checkOutput("bs_err",     {31'd0, res_err}, 32'd0);
        checkOutput("rdata_hold", bus.rdata,      32'hFFFF_FFDE);
        applyStimulus(1'b0, 1'b1, 32'h200, 32'h0000_7777, 2'b01, 1'b0, 0, 0);
        checkOutput("hs_cycles", res_cycles,  32'd4);
        checkOutput("hs_mem",    mem[9'h080], 32'h7777_33AB);

        $display("[TB] error requests");
        applyStimulus(1'b0, 1'b1, 32'h301, 32'h0000_1234, 2'b01, 1'b0, 0, 0);
        checkOutput("mh_cycles", res_cycles,       32'd2);
        checkOutput("mh_err",    {31'd0, res_err}, 32'd1);
        checkOutput("mh_enable", res_en,           32'd0);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 0, 0);
        checkOutput("sz11_err",  {31'd0, res_err}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, 0, 0);
        checkOutput("rw_err",    {31'd0, res_err}, 32'd1);
        checkOutput("rw_enable", res_en,           32'd0);
        applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 0, 0);
        checkOutput("mw_err",    {31'd0, res_err}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 1'b0, 0, 0);
        checkOutput("post_err_err",   {31'd0, res_err}, 32'd0);
        checkOutput("post_err_rdata", res_rdata,        32'h0000_00AD);

        $display("[TB] reset during write phase");
        memPreload(32'h400, 32'hA1B2_C3D4);
        @(negedge CLK);
        ready0         = ready_count;
        rd_delay       = 0;
        wr_delay       = 10;
        bus.req_wen    = 1'b1;
        bus.req_addr   = 32'h400;
        bus.req_wdata  = 32'h0000_5566;
        bus.req_size   = 2'b01;
        @(posedge CLK);
        #1;
        checkOutput("mid_rd_dREN", {31'd0, bus.dREN}, 32'd1);
        @(posedge CLK);
        #1;
        checkOutput("mid_wr_dWEN", {31'd0, bus.dWEN}, 32'd1);
        @(negedge CLK);
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("mid_rst_dWEN",  {31'd0, bus.dWEN},  32'd0);
        checkOutput("mid_rst_dREN",  {31'd0, bus.dREN},  32'd0);
        checkOutput("mid_rst_rdata", bus.rdata,          32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        driveIdle();
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("mid_no_ready", ready_count - ready0, 32'd0);
        checkOutput("mid_mem_kept", mem[9'h100],          32'hA1B2_C3D4);
        applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 0, 0);
        checkOutput("mid_load_rdata",  res_rdata,  32'hA1B2_C3D4);
        checkOutput("mid_load_cycles", res_cycles, 32'd3);

        $display("[TB] word store then back-to-back word load");
        applyStimulus(1'b0, 1'b1, 32'h500, 32'hCAFE_F00D, 2'b10, 1'b0, 0, 0);
        checkOutput("ws_cycles", res_cycles,   32'd3);
        checkOutput("ws_reads",  res_rd,       32'd0);
        checkOutput("ws_dstore", last_wr_data, 32'hCAFE_F00D);
        checkOutput("ws_mem",    mem[9'h140],  32'hCAFE_F00D);
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 2'b10, 1'b1, 0, 0);
        checkOutput("wl_rdata",  res_rdata,    32'hCAFE_F00D);
        checkOutput("wl_cycles", res_cycles,   32'd3);

        checkOutput("no_overlap", overlap_cycles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
